// File: rtl/pulse_sync_sched.sv
// Round-robin scheduler that serialises N single-cycle event strobes onto one
// toggle pulse-synchronizer channel, with a guard gap after every issued pulse.
module pulse_sync_sched #(
    parameter int unsigned N_REQ      = 4,
    parameter int unsigned ID_W       = $clog2(N_REQ),
    parameter int unsigned GAP_CYCLES = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic [N_REQ-1:0] req_pulse,
    input  logic             drop_clr,
    output logic             tx_pulse,
    output logic [ID_W-1:0]  tx_id,
    output logic             busy,
    output logic [N_REQ-1:0] pending,
    output logic [N_REQ-1:0] drop_flags
);

    localparam int unsigned CNT_W = $clog2(GAP_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        HOLD  = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [ID_W-1:0]  last_grant_q, last_grant_d;
    logic [ID_W-1:0]  tx_id_q, tx_id_d;
    logic [ID_W-1:0]  pick_c;
    logic             pick_vld_c;
    logic             tx_pulse_q, tx_pulse_d;
    logic             busy_q, busy_d;
    logic [N_REQ-1:0] pending_q, pending_d;
    logic [N_REQ-1:0] drop_q, drop_d;
    logic [N_REQ-1:0] grant_c;

    // Round-robin pick: scan from farthest to nearest so the nearest set bit after last_grant wins.
    always_comb begin
        int unsigned idx;
        pick_c     = last_grant_q;
        pick_vld_c = 1'b0;
        idx        = 0;
        for (int unsigned k = N_REQ; k >= 1; k--) begin
            idx = (32'(last_grant_q) + k) % N_REQ;
            if (pending_q[ID_W'(idx)]) begin
                pick_c     = ID_W'(idx);
                pick_vld_c = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        tx_id_d      = tx_id_q;
        last_grant_d = last_grant_q;
        grant_c      = '0;
        unique case (state_q)
            IDLE: begin
                if (enable && pick_vld_c) begin
                    state_d      = ISSUE;
                    tx_id_d      = pick_c;
                    last_grant_d = pick_c;
                    grant_c      = N_REQ'(1) << pick_c;
                end
            end
            ISSUE: begin
                cnt_d   = CNT_W'(GAP_CYCLES - 1);
                state_d = HOLD;
            end
            HOLD: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        tx_pulse_d = (state_d == ISSUE);
        busy_d     = (state_d != IDLE);
        // A strobe coinciding with its own grant re-arms the bit and is not a drop.
        pending_d  = req_pulse | (pending_q & ~grant_c);
        drop_d     = (req_pulse & pending_q & ~grant_c) | (drop_q & ~{N_REQ{drop_clr}});
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q        <= '0;
            last_grant_q <= ID_W'(N_REQ - 1);
            tx_id_q      <= '0;
            tx_pulse_q   <= 1'b0;
            busy_q       <= 1'b0;
            pending_q    <= '0;
            drop_q       <= '0;
        end else begin
            cnt_q        <= cnt_d;
            last_grant_q <= last_grant_d;
            tx_id_q      <= tx_id_d;
            tx_pulse_q   <= tx_pulse_d;
            busy_q       <= busy_d;
            pending_q    <= pending_d;
            drop_q       <= drop_d;
        end
    end

    assign tx_pulse   = tx_pulse_q;
    assign tx_id      = tx_id_q;
    assign busy       = busy_q;
    assign pending    = pending_q;
    assign drop_flags = drop_q;

endmodule

// File: tb/tb_pulse_sync_sched.sv
// Directed bench for pulse_sync_sched: per-cycle vector table plus sequences for
// burst ordering, round-robin fairness/drops and asynchronous reset mid-HOLD.
module tb_pulse_sync_sched;

    localparam int unsigned N   = 4;
    localparam int unsigned IDW = 2;

    logic           clk;
    logic           rst;
    logic           enable;
    logic [N-1:0]   req_pulse;
    logic           drop_clr;
    logic           tx_pulse;
    logic [IDW-1:0] tx_id;
    logic           busy;
    logic [N-1:0]   pending;
    logic [N-1:0]   drop_flags;

    pulse_sync_sched #(.N_REQ(4), .GAP_CYCLES(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .req_pulse  (req_pulse),
        .drop_clr   (drop_clr),
        .tx_pulse   (tx_pulse),
        .tx_id      (tx_id),
        .busy       (busy),
        .pending    (pending),
        .drop_flags (drop_flags)
    );

    typedef struct {
        logic           rst;
        logic           en;
        logic [N-1:0]   req;
        logic           clr;
        logic           pulse;
        logic [IDW-1:0] id;
        logic           busy;
        logic [N-1:0]   pend;
        logic [N-1:0]   drop;
    } vec_t;

    vec_t tbl[$];
    int   n_vec = 0;
    int   n_bad = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void add(input int n, input logic r, input logic e, input logic [N-1:0] rq,
                                input logic c, input logic p, input logic [IDW-1:0] id,
                                input logic b, input logic [N-1:0] pd, input logic [N-1:0] dr);
        vec_t v;
        v.rst = r; v.en = e; v.req = rq; v.clr = c;
        v.pulse = p; v.id = id; v.busy = b; v.pend = pd; v.drop = dr;
        for (int i = 0; i < n; i++) tbl.push_back(v);
    endfunction

    function automatic void cmp_all(input string nm, input logic p, input logic [IDW-1:0] id,
                                    input logic b, input logic [N-1:0] pd, input logic [N-1:0] dr);
        n_vec++;
        if ({tx_pulse, tx_id, busy, pending, drop_flags} !== {p, id, b, pd, dr}) begin
            n_bad++;
            $display("FAIL %s: got pulse=%b id=%0d busy=%b pend=%b drop=%b, expected pulse=%b id=%0d busy=%b pend=%b drop=%b",
                     nm, tx_pulse, tx_id, busy, pending, drop_flags, p, id, b, pd, dr);
        end
    endfunction

    function automatic void chk(input string nm, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
        end
    endfunction

    task automatic step(input logic r, input logic e, input logic [N-1:0] rq, input logic c);
        @(negedge clk);
        rst = r; enable = e; req_pulse = rq; drop_clr = c;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, 4'b0000, 1'b0);
    endtask

    initial begin
        int np;
        int ids[4];
        int at[4];
        rst = 1'b1; enable = 1'b0; req_pulse = '0; drop_clr = 1'b0;

        //   n  rst en  req     clr  pulse id busy pend     drop
        add(1,  1, 0, 4'b0000, 0,   0,   0, 0,   4'b0000, 4'b0000);  // reset state
        add(1,  0, 1, 4'b0100, 0,   0,   0, 0,   4'b0100, 4'b0000);  // single event
        add(1,  0, 1, 4'b0000, 0,   1,   2, 1,   4'b0000, 4'b0000);
        add(8,  0, 1, 4'b0000, 0,   0,   2, 1,   4'b0000, 4'b0000);
        add(1,  0, 1, 4'b0000, 0,   0,   2, 0,   4'b0000, 4'b0000);
        add(1,  0, 0, 4'b0010, 0,   0,   2, 0,   4'b0010, 4'b0000);  // enable gating
        add(2,  0, 0, 4'b0000, 0,   0,   2, 0,   4'b0010, 4'b0000);
        add(1,  0, 1, 4'b0000, 0,   1,   1, 1,   4'b0000, 4'b0000);
        add(8,  0, 1, 4'b0000, 0,   0,   1, 1,   4'b0000, 4'b0000);
        add(1,  0, 1, 4'b0000, 0,   0,   1, 0,   4'b0000, 4'b0000);
        add(1,  0, 1, 4'b0010, 0,   0,   1, 0,   4'b0010, 4'b0000);  // re-request at grant
        add(1,  0, 1, 4'b0010, 0,   1,   1, 1,   4'b0010, 4'b0000);
        add(8,  0, 1, 4'b0000, 0,   0,   1, 1,   4'b0010, 4'b0000);
        add(1,  0, 1, 4'b0000, 0,   0,   1, 0,   4'b0010, 4'b0000);
        add(1,  0, 1, 4'b0000, 0,   1,   1, 1,   4'b0000, 4'b0000);
        add(8,  0, 1, 4'b0000, 0,   0,   1, 1,   4'b0000, 4'b0000);
        add(1,  0, 1, 4'b0000, 0,   0,   1, 0,   4'b0000, 4'b0000);
        add(1,  0, 1, 4'b0001, 0,   0,   1, 0,   4'b0001, 4'b0000);  // drop and clear
        add(1,  0, 0, 4'b0001, 0,   0,   1, 0,   4'b0001, 4'b0001);
        add(1,  0, 0, 4'b0000, 1,   0,   1, 0,   4'b0001, 4'b0000);
        add(1,  0, 0, 4'b0001, 1,   0,   1, 0,   4'b0001, 4'b0001);
        add(1,  1, 0, 4'b0000, 0,   0,   0, 0,   4'b0000, 4'b0000);

        foreach (tbl[i]) begin
            step(tbl[i].rst, tbl[i].en, tbl[i].req, tbl[i].clr);
            cmp_all($sformatf("vec%0d", i), tbl[i].pulse, tbl[i].id, tbl[i].busy, tbl[i].pend, tbl[i].drop);
        end

        // Burst from reset: grant order 0,1,2,3, pulses 10 cycles apart.
        do_reset();
        step(1'b0, 1'b1, 4'b1111, 1'b0);
        np = 0;
        for (int c = 1; c <= 45; c++) begin
            step(1'b0, 1'b1, 4'b0000, 1'b0);
            if (tx_pulse) begin
                if (np < 4) begin ids[np] = int'(tx_id); at[np] = c; end
                np++;
            end
        end
        chk("burst_count", np, 4);
        for (int k = 0; k < 4; k++) begin
            if (k < np) begin
                chk($sformatf("burst_id%0d", k), ids[k], k);
                chk($sformatf("burst_cycle%0d", k), at[k], 1 + 10 * k);
            end
        end
        chk("burst_drops", int'(drop_flags), 0);

        // Fairness: requesters 0 and 3 strobe every cycle.
        do_reset();
        np = 0;
        for (int c = 1; c <= 45; c++) begin
            step(1'b0, 1'b1, 4'b1001, 1'b0);
            if (tx_pulse) begin
                if (np < 4) begin ids[np] = int'(tx_id); at[np] = c; end
                np++;
            end
        end
        chk("rr_count", np, 5);
        for (int k = 0; k < 4; k++) begin
            if (k < np) begin
                chk($sformatf("rr_id%0d", k), ids[k], (k % 2 == 0) ? 0 : 3);
                chk($sformatf("rr_cycle%0d", k), at[k], 2 + 10 * k);
            end
        end
        chk("rr_drops", int'(drop_flags), 9);
        step(1'b0, 1'b0, 4'b0001, 1'b1);
        chk("rr_clr_recur", int'(drop_flags), 1);
        step(1'b0, 1'b0, 4'b0000, 1'b1);
        chk("rr_clr_all", int'(drop_flags), 0);

        // Asynchronous reset three cycles into HOLD with requester 3 pending.
        do_reset();
        step(1'b0, 1'b1, 4'b0001, 1'b0);
        step(1'b0, 1'b1, 4'b1000, 1'b0);
        cmp_all("ar_issue", 1'b1, 2'd0, 1'b1, 4'b1000, 4'b0000);
        for (int c = 0; c < 3; c++) step(1'b0, 1'b1, 4'b0000, 1'b0);
        cmp_all("ar_hold", 1'b0, 2'd0, 1'b1, 4'b1000, 4'b0000);
        #1;
        rst = 1'b1;
        #1;
        cmp_all("ar_async", 1'b0, 2'd0, 1'b0, 4'b0000, 4'b0000);
        np = 0;
        for (int c = 0; c < 20; c++) begin
            step(1'b0, 1'b1, 4'b0000, 1'b0);
            if (tx_pulse || busy) np++;
        end
        chk("ar_no_pulse", np, 0);
        chk("ar_pending", int'(pending), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/pulse_sync_sched.md
Name: pulse_sync_sched

Overview:
- Arbitrates N single-cycle event requesters onto one shared toggle-based pulse synchronizer channel.
- Drives the synchronizer's `src_pulse` together with a stable event-ID tag.
- Enforces a minimum guard gap between issued pulses, so the destination cannot merge two toggles into one.
- Lives entirely in the source clock domain, directly upstream of the pulse synchronizer instance.

Parameters:
- N_REQ, 4, number of requesters (≥2).
- ID_W, $clog2(N_REQ), width of the issued event ID (derived; do not override).
- GAP_CYCLES, 8, source-clock cycles held idle after each issued pulse (≥1). Integration sets it to at least 3 destination cycles expressed in source cycles.

Ports:
- clk, input, 1, source-domain clock.
- rst, input, 1, asynchronous active-high reset.
- enable, input, 1, permits new grants when high.
- req_pulse, input, N_REQ, per-requester single-cycle event strobes.
- drop_clr, input, 1, clears all drop_flags.
- tx_pulse, output, 1, one-cycle strobe to the synchronizer `src_pulse`.
- tx_id, output, ID_W, index of the requester being/last serviced; stable between grants.
- busy, output, 1, high in ISSUE or HOLD.
- pending, output, N_REQ, registered sticky request bits.
- drop_flags, output, N_REQ, sticky: an event arrived while the same requester was already pending.

Behaviour:
- Reset values (async, immediate on rst):
  - state=IDLE.
  - tx_pulse=0, tx_id=0, busy=0, pending=0, drop_flags=0.
  - Hold counter=0; last_grant=N_REQ-1, so requester 0 has first priority.
- Pending capture (each clk edge, per bit i):
  - Set when req_pulse[i] is high.
  - Cleared when i is granted, unless req_pulse[i] is high that same cycle; then it stays set and no drop is flagged.
  - If req_pulse[i] is high while pending[i] is already set and not being granted: drop_flags[i] is set.
  - drop_flags are sticky until drop_clr. Set wins over drop_clr in the same cycle.
- FSM, all outputs registered:
  - IDLE: if enable and pending≠0, go to ISSUE.
    - Round-robin pick: first set bit searching upward from last_grant+1, with wrap-around.
    - Load tx_id and last_grant with the pick; clear that pending bit.
  - ISSUE: tx_pulse=1 for exactly this one cycle. Load counter=GAP_CYCLES-1 and go to HOLD.
  - HOLD: tx_pulse=0. Decrement each cycle; at counter=0 go to IDLE. HOLD lasts exactly GAP_CYCLES cycles.
- Latency:
  - req_pulse sampled at edge k sets pending at edge k.
  - Grant at edge k+1; tx_pulse is high in the cycle after edge k+1, i.e. 2 cycles from strobe to pulse when idle.
- Throughput: with continuous backlog, tx_pulse rising edges are exactly GAP_CYCLES+2 cycles apart (1 ISSUE + GAP_CYCLES HOLD + 1 IDLE).
- tx_id:
  - Changes only on the IDLE→ISSUE edge.
  - Constant through ISSUE, HOLD and the following IDLE cycles until the next grant.
- enable deasserted:
  - In IDLE: no grant.
  - In ISSUE/HOLD: the current transaction completes normally.
  - pending keeps capturing and is retained.
- rst mid-HOLD or mid-ISSUE: the transaction is abandoned and all pending events are discarded.
- Counter width: $clog2(GAP_CYCLES+1), with no wrap in normal operation.

Test Plan:
- Single event, idle: reset, enable=1, req_pulse=4'b0100 for one cycle at edge k → pending[2]=1 after edge k. Then tx_id=2 and tx_pulse=1 for exactly one cycle, 2 cycles after the strobe. busy=1 for 1+8 cycles, then 0.
- Burst, all requesters: req_pulse=4'b1111 for one cycle → four tx_pulses with tx_id sequence 0,1,2,3, rising edges 10 cycles apart (GAP_CYCLES=8). No drops.
- Round-robin fairness: hold req_pulse[0] and req_pulse[3] high on every cycle → tx_id alternates 0,3,0,3. drop_flags[0] and drop_flags[3] are set. drop_clr → flags cleared unless a drop recurs in that same cycle.
- Re-request at grant: req_pulse[1] high on the exact cycle pending[1] is granted → pending[1] remains 1, drop_flags[1]=0, and a second tx_pulse with tx_id=1 follows after the gap.
- enable gating: enable=0 with req_pulse=4'b0010 → no tx_pulse and pending[1]=1 held. enable=1 → tx_pulse 1 cycle later with tx_id=1.
- Async reset mid-HOLD: assert rst 3 cycles into HOLD with pending=4'b1000 → all outputs 0 immediately, without waiting for clk. After release, no tx_pulse occurs until a new request.
